// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multiply/divide unit with dedicated HI/LO
//                registers. Executes MULT, MULTU, DIV, DIVU in WIDTH+1
//                cycles (WIDTH iterations plus one sign-fixup/write cycle)
//                and services MTHI/MTLO moves while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    // Counter only needs to reach WIDTH-1.
    localparam int               CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // Multiply: full 2*WIDTH product/multiplier shift register.
    // Divide:   low half holds dividend bits shifting out / quotient shifting in.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Partial remainder for divide; its implicit extra bit lives in div_shift.
    logic [WIDTH-1:0]     rem_q, rem_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 res_neg_q, res_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Operand conditioning at launch: magnitudes only for the signed ops.
    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    // Per-iteration datapath results.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem_next;
    logic [WIDTH-1:0]     div_quo_next;

    // Final sign-corrected results written during FIX.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Launch-time operand magnitudes and sign flags.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & busA[WIDTH-1];
        b_neg     = signed_op & busB[WIDTH-1];
        a_mag     = a_neg ? (~busA + 1'b1) : busA;
        b_mag     = b_neg ? (~busB + 1'b1) : busB;
    end

    // One shift-add step and one restoring-divide step, both from current state.
    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole product right by one.
        mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next     = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: bring in the next dividend bit, trial-subtract,
        // keep the difference only if it did not go negative.
        div_shift    = {rem_q, acc_q[WIDTH-1]};
        div_diff     = div_shift - {1'b0, opnd_q};
        div_ge       = ~div_diff[WIDTH];
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_next = {acc_q[WIDTH-2:0], div_ge};
    end

    // Sign fixup. Divide-by-zero forces an all-ones quotient; the remainder
    // then equals the original dividend once its sign is restored.
    always_comb begin
        prod_fix = res_neg_q ? (~acc_q + 1'b1) : acc_q;
        if (dbz_q) begin
            quo_fix = {WIDTH{1'b1}};
        end else begin
            quo_fix = res_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        end
        rem_fix = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Next-state and datapath control for IDLE -> RUN -> FIX -> IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // start has priority; any simultaneous move is dropped.
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dbz_d     = (busB == '0);
                    rem_d     = '0;
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end else begin
                    if (mthi) begin
                        hi_d = busA;
                    end
                    if (mtlo) begin
                        lo_d = busA;
                    end
                end
            end

            S_RUN: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo_next};
                    rem_d = div_rem_next;
                end else begin
                    acc_d = mul_next;
                end
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // HI/LO change only here, both in the same edge.
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the single-cycle datapath, sitting directly downstream of the register file. It takes the two register read buses (rs on `busA`, rt on `busB`) and executes MULT, MULTU, DIV, DIVU over 33 cycles. Results go into dedicated HI/LO registers. It also services MTHI/MTLO writes. `busy` is the stall signal the control unit holds the pipeline on.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. Iteration count equals `WIDTH`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch an operation. Sampled only while idle.
- `op` in 2: operation select. 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `mthi` in 1: write `busA` into HI. Honoured only while idle.
- `mtlo` in 1: write `busA` into LO. Honoured only while idle.
- `busA` in WIDTH: rs value, used as multiplicand or dividend.
- `busB` in WIDTH: rt value, used as multiplier or divisor.
- `hi` out WIDTH: HI register (registered).
- `lo` out WIDTH: LO register (registered).
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when HI/LO have just been updated by an operation.

## Operation
- **Reset:** reset is asynchronous and active-low.
  - `hi`, `lo` = 0; `busy` = 0; `done` = 0; state = IDLE.
  - Internal accumulator, counter and sign flags are cleared.
  - Reset mid-operation abandons the operation; HI/LO return to 0, not to their prior values.
- **State machine:** IDLE -> RUN -> FIX -> IDLE.
- **IDLE:**
  - `start` = 1: capture the operands and go to RUN.
    - Capture `|busA|` and `|busB|`; magnitudes are taken only for signed ops (`op` 0 and 2).
    - Record the result sign = `busA[31] ^ busB[31]` and the remainder sign = `busA[31]`.
    - Record `op`; set counter = 0.
  - `mthi` or `mtlo` without `start`: write `busA` into HI or LO. Both together write both.
  - `start` together with `mthi`/`mtlo`: `start` wins; the move is dropped.
- **RUN, multiply:** radix-2 shift-add over a 2·WIDTH product, one multiplier bit per cycle, LSB first.
- **RUN, divide:** restoring division, one quotient bit per cycle, MSB first, on a WIDTH+1-bit partial remainder.
- **RUN exit:** after counter reaches WIDTH-1, go to FIX.
- **FIX, signed ops:**
  - Multiply: negate the 64-bit product if the result sign is set.
  - Divide: negate the quotient if the result sign is set; negate the remainder if the remainder sign is set.
- **FIX, result write:**
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- **Divide by zero (`busB` = 0):** LO = 32'hFFFF_FFFF, HI = dividend as originally presented (sign preserved). Latency is unchanged; this is not flagged.
- **Signed overflow (0x8000_0000 DIV 0xFFFF_FFFF):** LO = 0x8000_0000, HI = 0. This falls out of the magnitude arithmetic and is not a special case.
- **While busy:** `start`, `mthi`, `mtlo` are ignored, and `busA`/`busB` may change freely.
- **HI/LO stability:** HI/LO hold their old values until the FIX edge. They are never partially updated.

## Timing
- **Launch:** `start` is sampled at edge E0. `busy` = 1 from after E0 through E33.
- **Iterations:** edges E1..E32 perform the 32 iterations.
- **Completion, edge E33 (FIX):**
  - HI/LO are written.
  - `done` rises and `busy` falls.
  - State returns to IDLE.
- **`done`:** `done` clears at E34.
- **Back-to-back launch:** a new `start` may be asserted in the cycle after E33, i.e. while `done` = 1, and is accepted at E34.
- **Total latency:** 33 cycles from the start edge to valid HI/LO.
- **MTHI/MTLO:** take effect at the sampling edge; visible on `hi`/`lo` the next cycle.
- **No bypass:** all outputs are registered, with no combinational path from the inputs.

## Test plan
- **MULT:** MULT 0xFFFF_FFFE × 0x0000_0003 -> after 33 cycles HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFA; `done` high exactly one cycle; `busy` high exactly 33 cycles.
- **MULTU / DIVU:**
  - MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> HI = 0xFFFF_FFFE, LO = 0x0000_0001.
  - DIVU 100 / 7 -> LO = 14, HI = 2.
- **Signed DIV:**
  - DIV −7 / 2 -> LO = 0xFFFF_FFFD (−3), HI = 0xFFFF_FFFF (−1).
  - DIV 0x8000_0000 / −1 -> LO = 0x8000_0000, HI = 0.
  - DIV 5 / 0 -> LO = 0xFFFF_FFFF, HI = 5.
- **Ignored inputs while busy:**
  - Assert `start` and `mthi` during RUN with different operands -> result matches the first operation; HI is not overwritten.
  - Next `start` asserted in the `done` cycle is accepted.
- **Moves:**
  - MTHI 0x1234_5678 and MTLO 0xCAFE_F00D in idle -> `hi`/`lo` updated the next cycle.
  - `start` with `mtlo` in the same cycle -> move dropped; LO later holds the operation result.
- **Reset mid-op:** drop `rst_n` at cycle 10 of a DIV -> `hi` = `lo` = 0, `busy` = `done` = 0 immediately, without a clock edge. After release, a fresh MULT 6 × 7 gives LO = 42, HI = 0.
